// File: rtl/pal_chroma_modulator.sv
// PAL quadrature chroma modulator: DDS subcarrier, V-switch, burst insertion.
// Three-stage pipeline (select/LUT, multiply, sum/round/clamp), one sample per clk.
module pal_chroma_modulator #(
    parameter logic [31:0] PHASE_INC = 32'd396713491,
    parameter int          BURST_AMP = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] u_in,
    input  logic [5:0] v_in,
    input  logic       active,
    input  logic       burst_en,
    input  logic       line_start,
    input  logic       frame_start,
    output logic [7:0] chroma_out,
    output logic       v_switch
);

    localparam logic signed [6:0] BURST = 7'(BURST_AMP);

    // First quadrant of round(63*sin(2*pi*k/256)), k = 0..64; the rest is mirrored.
    localparam logic [5:0] QTAB [65] = '{
        0, 2, 3, 5, 6, 8, 9, 11, 12, 14, 15, 17, 18, 20, 21, 23,
        24, 26, 27, 28, 30, 31, 32, 34, 35, 36, 38, 39, 40, 41, 42, 43,
        45, 46, 47, 48, 49, 50, 51, 52, 52, 53, 54, 55, 56, 56, 57, 58,
        58, 59, 59, 60, 60, 61, 61, 61, 62, 62, 62, 63, 63, 63, 63, 63,
        63
    };

    function automatic logic signed [6:0] sine(input logic [7:0] idx);
        logic [6:0] k;
        logic signed [6:0] mag;
        k   = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
        mag = $signed({1'b0, QTAB[k]});
        return idx[7] ? -mag : mag;
    endfunction

    // Assertion is immediate; release is delayed two clocks to stay clean of clk.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int_n = rst_sync[1];

    logic [31:0] phase;
    logic        vsw;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            phase <= '0;
            vsw   <= 1'b0;
        end else begin
            phase <= phase + PHASE_INC;
            if (frame_start)     vsw <= 1'b0;
            else if (line_start) vsw <= ~vsw;
        end
    end

    assign v_switch = vsw;

    // Stage 0: source select and V inversion in 7 bits, so -(-32) stays representable.
    logic signed [6:0] u_sel, v_sel, v_mod;

    always_comb begin
        u_sel = '0;
        v_sel = '0;
        if (burst_en) begin
            u_sel = -BURST;
            v_sel = BURST;
        end else if (active) begin
            u_sel = $signed({u_in[5], u_in});
            v_sel = $signed({v_in[5], v_in});
        end
        v_mod = vsw ? -v_sel : v_sel;
    end

    logic signed [6:0]  u_r, v_r, sin_r, cos_r;
    logic signed [13:0] pu_r, pv_r;
    logic signed [14:0] sum_s, rnd_s, shf_s;
    logic signed [7:0]  clamp_s;

    always_comb begin
        sum_s   = 15'(pu_r) + 15'(pv_r);
        rnd_s   = sum_s + 15'sd16;
        shf_s   = rnd_s >>> 5;
        clamp_s = 8'(shf_s);
        if (shf_s > 15'sd127)       clamp_s = 8'sd127;
        else if (shf_s < -15'sd127) clamp_s = -8'sd127;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            u_r        <= '0;
            v_r        <= '0;
            sin_r      <= '0;
            cos_r      <= '0;
            pu_r       <= '0;
            pv_r       <= '0;
            chroma_out <= '0;
        end else begin
            u_r        <= u_sel;
            v_r        <= v_mod;
            sin_r      <= sine(phase[31:24]);
            cos_r      <= sine(phase[31:24] + 8'd64);
            pu_r       <= u_r * sin_r;
            pv_r       <= v_r * cos_r;
            chroma_out <= clamp_s;
        end
    end

endmodule

// File: tb/tb_pal_chroma_modulator.sv
// Scoreboard bench for pal_chroma_modulator: directed vectors on a quarter-rate
// subcarrier instance plus a full-scale sweep on a one-index-per-clk instance.
module tb_pal_chroma_modulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] u_in, v_in;
    logic       active, burst_en, line_start, frame_start;
    logic [7:0] chroma_out;
    logic       v_switch;

    logic [5:0] sw_u, sw_v;
    logic       sw_act, sw_burst, sw_ls, sw_fs;
    logic [7:0] sw_out;
    logic       sw_vs;

    always #5 clk = ~clk;

    pal_chroma_modulator #(.PHASE_INC(32'h4000_0000), .BURST_AMP(16)) dut (
        .clk(clk), .rst_n(rst_n), .u_in(u_in), .v_in(v_in), .active(active),
        .burst_en(burst_en), .line_start(line_start), .frame_start(frame_start),
        .chroma_out(chroma_out), .v_switch(v_switch)
    );

    pal_chroma_modulator #(.PHASE_INC(32'h0100_0000), .BURST_AMP(12)) dut_sw (
        .clk(clk), .rst_n(rst_n), .u_in(sw_u), .v_in(sw_v), .active(sw_act),
        .burst_en(sw_burst), .line_start(sw_ls), .frame_start(sw_fs),
        .chroma_out(sw_out), .v_switch(sw_vs)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic       cur_tag  = 1'b0;
    logic [2:0] tag_pipe;
    int         ph       = 0;
    logic       vs_m     = 1'b0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    endtask

    // Hand model: at PHASE_INC = 2^30 the LUT index walks 0,64,128,192.
    function automatic int model(input int u, input int v, input logic act,
                                 input logic bst, input logic vs, input int p);
        int up, vp, sn, cs, s, r;
        up = 0;
        vp = 0;
        if (bst) begin
            up = -16;
            vp = 16;
        end else if (act) begin
            up = u;
            vp = v;
        end
        if (vs) vp = -vp;
        sn = (p == 1) ? 63 : (p == 3) ? -63 : 0;
        cs = (p == 0) ? 63 : (p == 2) ? -63 : 0;
        s  = up * sn + vp * cs;
        r  = (s + 16) >>> 5;
        if (r > 127)  r = 127;
        if (r < -127) r = -127;
        return r;
    endfunction

    task automatic step(input int u, input int v, input logic act, input logic bst,
                        input logic ls, input logic fs, input logic chk);
        u_in        = 6'(u);
        v_in        = 6'(v);
        active      = act;
        burst_en    = bst;
        line_start  = ls;
        frame_start = fs;
        cur_tag     = chk;
        if (chk) exp_q.push_back(8'(model(u, v, act, bst, vs_m, ph)));
        @(posedge clk);
        #1;
        ph = (ph + 1) % 4;
        if (fs)      vs_m = 1'b0;
        else if (ls) vs_m = ~vs_m;
        check("v_switch", int'(v_switch), int'(vs_m));
    endtask

    // Each issued sample emerges on chroma_out three clocks later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_pipe <= 3'b000;
        else        tag_pipe <= {tag_pipe[1:0], cur_tag};
    end

    always @(negedge clk) begin
        if (tag_pipe[2]) begin
            if (exp_q.size() == 0) begin
                check("chroma_underflow", 1, 0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("chroma", int'($signed(chroma_out)), int'($signed(e)));
            end
        end
    end

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(20, 0, 1, 0, 0, 0, 0);
        step(20, 0, 1, 0, 0, 0, 0);
        ph = 0;
    endtask

    initial begin
        int mx, mn;
        int uv_tab[6][2];
        uv_tab = '{'{-32, 31}, '{31, -32}, '{-32, -32}, '{31, 31}, '{-7, 13}, '{25, -18}};
        rst_n = 1'b0;
        {u_in, v_in, active, burst_en, line_start, frame_start} = '0;
        sw_u = 6'h20; sw_v = 6'h20; sw_act = 1'b1;
        sw_burst = 1'b0; sw_ls = 1'b0; sw_fs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_chroma", int'($signed(chroma_out)), 0);
        check("reset_vswitch", int'(v_switch), 0);
        release_reset();

        for (int i = 0; i < 400; i++) step(0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)   step(20, 0, 1, 0, 0, 0, 1);

        for (int i = 0; i < 4; i++)   step(0, 20, 1, 0, 0, 0, 1);
        step(0, 20, 1, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++)   step(0, 20, 1, 0, 0, 0, 1);
        step(0, 20, 1, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++)   step(0, 20, 1, 0, 0, 0, 1);
        step(0, 20, 1, 0, 1, 0, 1);
        step(0, 20, 1, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++)   step(0, 20, 1, 0, 0, 0, 1);

        for (int i = 0; i < 4; i++)   step(31, 0, 1, 1, 0, 0, 1);
        step(31, 0, 1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++)   step(31, 0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++)   step(31, 5, 0, 0, 0, 0, 1);

        for (int i = 0; i < 4; i++)   step(0, -32, 1, 0, 0, 0, 1);
        step(0, -32, 1, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++)   step(0, -32, 1, 0, 0, 0, 1);
        for (int t = 0; t < 6; t++)
            for (int i = 0; i < 4; i++) step(uv_tab[t][0], uv_tab[t][1], 1, 0, (i == 0), 0, 1);

        if (!vs_m) step(17, 20, 1, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++)   step(17, 20, 1, 0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_chroma", int'($signed(chroma_out)), 0);
        check("midreset_vswitch", int'(v_switch), 0);
        exp_q.delete();
        cur_tag = 1'b0;
        vs_m    = 1'b0;
        release_reset();
        for (int i = 0; i < 8; i++)   step(20, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++)   step(0, 0, 0, 0, 0, 0, 0);
        check("queue_drained", exp_q.size(), 0);

        mx = -1000;
        mn = 1000;
        repeat (300) begin
            @(negedge clk);
            if (int'($signed(sw_out)) > mx) mx = int'($signed(sw_out));
            if (int'($signed(sw_out)) < mn) mn = int'($signed(sw_out));
        end
        check("sweep_max", mx, 90);
        check("sweep_min", mn, -90);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pal_chroma_modulator.md
Name: pal_chroma_modulator

Overview:
- Quadrature modulator directly downstream of the PAL chroma lowpass filters (one instance for U, one for V).
- Takes band-limited 6-bit signed U/V and multiplies them onto a DDS-generated PAL subcarrier.
- Applies the PAL V-switch (per-line V inversion) and inserts the colour burst.
- Outputs 8-bit signed chroma to the composite summing stage.

Parameters:
- PHASE_INC, 396713491, 32-bit DDS increment per clk (4.43361875 MHz at 48 MHz clk).
- BURST_AMP, 12, burst magnitude injected on both U and V axes (0..31).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- u_in  in  6  signed U from chroma lowpass.
- v_in  in  6  signed V from chroma lowpass.
- active  in  1  active-video window; chroma passes only while high.
- burst_en  in  1  burst window from timing generator.
- line_start  in  1  single-cycle pulse at start of each line.
- frame_start  in  1  single-cycle pulse at start of each field.
- chroma_out  out  8  signed modulated chroma.
- v_switch  out  1  current PAL V-inversion state (1 = V inverted).

Behaviour:
- Reset (rst_n low, async):
  - chroma_out = 0, v_switch = 0, phase accumulator = 0.
  - All pipeline registers clear.
  - Deassertion is synchronised internally.
- Phase accumulator (32 bit):
  - phase <= phase + PHASE_INC every clk, wrapping modulo 2^32.
  - Runs continuously regardless of active/burst_en.
- LUT:
  - 256-entry sine table, idx = phase[31:24], value round(63*sin(2*pi*idx/256)), 7-bit signed.
  - sin = lut[idx], cos = lut[(idx+64) mod 256].
- V-switch:
  - Toggles on each line_start.
  - frame_start forces 0.
  - If both pulse in the same cycle, frame_start wins: v_switch = 0.
  - Updated value takes effect from the cycle after the pulse.
- Source select (stage 0):
  - If burst_en: U' = -BURST_AMP, V' = +BURST_AMP. Burst lands at 135 deg, or 225 deg on inverted lines.
  - Else if active: U' = u_in, V' = v_in.
  - Else: U' = V' = 0.
  - burst_en has priority over active.
  - U'/V' are sign-extended to 7 bits before negation, so V = -32 inverts to +32 without overflow.
  - If v_switch = 1: V' = -V'.
  - Register U', V', sin, cos.
- Stage 1: pu = U'*sin, pv = V'*cos, each 14-bit signed; register both.
- Stage 2:
  - s = pu + pv (15-bit).
  - chroma_out = clamp((s + 16) >>> 5, -127, 127).
  - Arithmetic shift floors toward minus infinity.
- Latency:
  - Inputs, and the phase sampled in cycle N, appear on chroma_out in cycle N+3.
  - Throughput is 1 sample/clk.
- Mid-operation reset returns to the reset state immediately. The first valid output is 3 clks after deassertion.

Test Plan:
- Reset: assert rst_n low mid-stream with nonzero u_in/v_in -> chroma_out = 0 and v_switch = 0 within the same cycle; after release the phase restarts at 0.
- Zero input: u_in = v_in = 0, active = 1, 1000 clks -> chroma_out = 0 on every cycle.
- U modulation: PHASE_INC = 2^30 (idx sequence 0,64,128,192), u_in = 20, v_in = 0, active = 1 -> chroma_out sequence 0, 39, 0, -39 repeating, starting 3 clks after the first sample.
- V-switch: PHASE_INC = 0, u_in = 0, v_in = 20, active = 1 -> chroma_out = 39; pulse line_start -> -39 (after 3-clk latency); pulse again -> 39. Pulse line_start and frame_start together -> v_switch = 0, output 39.
- Burst: PHASE_INC = 0, BURST_AMP = 16, burst_en = 1, active = 1, u_in = 31 -> chroma_out = 32 (burst overrides active); after line_start -> -31; burst_en = 0 and active = 0 -> 0.
- Extremes: v_in = -32, v_switch = 1, idx = 0 -> product 2016, out (2016+16)>>>5 = 63. Full-scale sweep of u_in/v_in at all 256 idx -> no wraparound, |chroma_out| <= 127.
